// File: rtl/one_hot_rx.sv
// one_hot_rx: checks an 8-bit one-hot lane for validity and +1 mod 8 sequencing, with HUNT/CHECK/LOCKED sync.
// ONE_HOT_RX_ERR_CNT_EN enables the saturating miss counter; otherwise err_count is tied to 0.
module one_hot_rx #(
    parameter int LOCK_CNT   = 4,
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             go,
    input  logic [7:0]       one_hot_in,
    input  logic             clr_err,
    output logic [2:0]       index,
    output logic             valid,
    output logic             onehot_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [1:0] HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2;
    logic [1:0] state, state_nx;
    logic [2:0] expected, pos;
    logic [3:0] good_run, good_run_nx, miss_run, miss_run_nx;
    logic good, seq_miss, miss;
    always_comb begin
        pos = '0;
        for (int i = 0; i < 8; i++)
            if (one_hot_in[i]) pos = 3'(i);
    end
    // x & (x-1) clears the lowest set bit, so zero leftover means at most one bit set
    assign good     = |one_hot_in && ((one_hot_in & (one_hot_in - 8'd1)) == 8'd0);
    assign seq_miss = good && state != HUNT && pos != expected;
    assign miss     = go && (!good || seq_miss);
    always_comb begin
        state_nx    = state;
        good_run_nx = good_run;
        miss_run_nx = miss_run;
        if (go)
            case (state)
                HUNT: if (good) begin
                    state_nx    = CHECK;
                    good_run_nx = 4'd1;
                end
                CHECK: if (miss) begin
                    state_nx    = HUNT;
                    good_run_nx = '0;
                end else begin
                    good_run_nx = good_run + 4'd1;
                    if (good_run + 4'd1 == 4'(LOCK_CNT)) begin
                        state_nx    = LOCKED;
                        miss_run_nx = '0;
                    end
                end
                LOCKED: if (miss) begin
                    miss_run_nx = miss_run + 4'd1;
                    if (miss_run + 4'd1 == 4'(MISS_LIMIT)) begin
                        state_nx    = HUNT;
                        good_run_nx = '0;
                    end
                end else
                    miss_run_nx = '0;
                default: state_nx = HUNT;
            endcase
    end
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            state      <= HUNT;
            good_run   <= '0;
            miss_run   <= '0;
            expected   <= '0;
            index      <= '0;
            valid      <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nx;
            good_run   <= good_run_nx;
            miss_run   <= miss_run_nx;
            valid      <= go && good;
            onehot_err <= go && !good;
            seq_err    <= go && seq_miss;
            locked     <= state_nx == LOCKED;
            // mismatching good samples also reload expected so the checker resyncs
            if (go && good) begin
                index    <= pos;
                expected <= pos + 3'd1;
            end
        end
`ifdef ONE_HOT_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge nreset)
        if (!nreset)
            err_count <= '0;
        else if (clr_err)
            err_count <= '0;
        else if (miss && err_count != '1)
            err_count <= err_count + ERR_W'(1);
`else
    logic unused_clr;
    assign unused_clr = clr_err;
    assign err_count  = '0;
`endif
endmodule

// File: tb/tb_one_hot_rx.sv
// tb_one_hot_rx: directed vector table plus randomized run against a rule-level model of one_hot_rx.
module tb_one_hot_rx;
    localparam int LOCK_CNT = 4, MISS_LIMIT = 2, ERR_W = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    logic clk = 0, nreset = 0, go = 0, clr_err = 0;
    logic [7:0] one_hot_in = '0;
    logic [2:0] index;
    logic valid, onehot_err, seq_err, locked;
    logic [ERR_W-1:0] err_count;
    int checks = 0, errors = 0;

    one_hot_rx #(.LOCK_CNT(LOCK_CNT), .MISS_LIMIT(MISS_LIMIT), .ERR_W(ERR_W)) dut (
        .clk(clk), .nreset(nreset), .go(go), .one_hot_in(one_hot_in), .clr_err(clr_err),
        .index(index), .valid(valid), .onehot_err(onehot_err), .seq_err(seq_err),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       g;
        logic [7:0] d;
        logic       c;
        logic       v;
        logic [2:0] i;
        logic       oe;
        logic       se;
        logic       lk;
        int         e;
    } vec_t;

    // 0 = hunt, 1 = check, 2 = locked
    int m_state, m_gr, m_mr, m_exp, m_idx, m_err;
    bit m_v, m_oe, m_se;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int feat_err(input int e);
`ifdef ONE_HOT_RX_ERR_CNT_EN
        return e;
`else
        return 0;
`endif
    endfunction

    task automatic chk_all(input string tag, input int v, input int i, input int oe,
                           input int se, input int lk, input int e);
        chk({tag, ".valid"}, int'(valid), v);
        chk({tag, ".index"}, int'(index), i);
        chk({tag, ".onehot_err"}, int'(onehot_err), oe);
        chk({tag, ".seq_err"}, int'(seq_err), se);
        chk({tag, ".locked"}, int'(locked), lk);
        chk({tag, ".err_count"}, int'(err_count), feat_err(e));
    endtask

    task automatic model_reset();
        m_state = 0; m_gr = 0; m_mr = 0; m_exp = 0; m_idx = 0; m_err = 0;
        m_v = 0; m_oe = 0; m_se = 0;
    endtask

    task automatic model_step(input bit g, input logic [7:0] d, input bit c);
        bit miss;
        int p;
        m_v = 0; m_oe = 0; m_se = 0;
        if (g) begin
            if ($countones(d) == 1) begin
                p = 0;
                while (d[p] == 1'b0) p++;
                m_v = 1;
                m_se = (m_state != 0) && (p != m_exp);
                m_idx = p;
                m_exp = (p + 1) % 8;
            end else
                m_oe = 1;
        end
        miss = m_oe || m_se;
        if (g)
            case (m_state)
                0: if (m_v) begin m_state = 1; m_gr = 1; end
                1: if (miss) begin m_state = 0; m_gr = 0; end
                   else begin
                       m_gr++;
                       if (m_gr == LOCK_CNT) begin m_state = 2; m_mr = 0; end
                   end
                default: if (miss) begin
                       m_mr++;
                       if (m_mr == MISS_LIMIT) begin m_state = 0; m_gr = 0; end
                   end else
                       m_mr = 0;
            endcase
        if (c) m_err = 0;
        else if (miss && m_err < ERR_MAX) m_err++;
    endtask

    vec_t tbl[27];

    initial begin
        tbl[0]  = '{1, 8'h01, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 8'h02, 0, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 8'h04, 0, 1, 2, 0, 0, 0, 0};
        tbl[3]  = '{1, 8'h08, 0, 1, 3, 0, 0, 1, 0};
        for (int k = 4; k < 9; k++) tbl[k] = '{0, 8'h55, 0, 0, 3, 0, 0, 1, 0};
        tbl[9]  = '{1, 8'h10, 0, 1, 4, 0, 0, 1, 0};
        tbl[10] = '{1, 8'h20, 0, 1, 5, 0, 0, 1, 0};
        tbl[11] = '{1, 8'h40, 0, 1, 6, 0, 0, 1, 0};
        tbl[12] = '{1, 8'h80, 0, 1, 7, 0, 0, 1, 0};
        tbl[13] = '{1, 8'h01, 0, 1, 0, 0, 0, 1, 0};
        tbl[14] = '{1, 8'h02, 0, 1, 1, 0, 0, 1, 0};
        tbl[15] = '{1, 8'h10, 0, 1, 4, 0, 1, 1, 1};
        tbl[16] = '{1, 8'h20, 0, 1, 5, 0, 0, 1, 1};
        tbl[17] = '{1, 8'h00, 0, 0, 5, 1, 0, 1, 2};
        tbl[18] = '{1, 8'h03, 0, 0, 5, 1, 0, 0, 3};
        tbl[19] = '{1, 8'h00, 0, 0, 5, 1, 0, 0, 3};
        tbl[20] = '{1, 8'h00, 1, 0, 5, 1, 0, 0, 0};
        tbl[21] = '{1, 8'hFF, 0, 0, 5, 1, 0, 0, 1};
        tbl[22] = '{0, 8'h00, 1, 0, 5, 0, 0, 0, 0};
        tbl[23] = '{1, 8'h80, 0, 1, 7, 0, 0, 0, 0};
        tbl[24] = '{1, 8'h01, 0, 1, 0, 0, 0, 0, 0};
        tbl[25] = '{1, 8'h04, 0, 1, 2, 0, 1, 0, 1};
        tbl[26] = '{1, 8'h08, 0, 1, 3, 0, 0, 0, 1};

        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        nreset = 1;
        for (int k = 0; k < 27; k++) begin
            go = tbl[k].g; one_hot_in = tbl[k].d; clr_err = tbl[k].c;
            @(negedge clk);
            chk_all($sformatf("vec%0d", k), tbl[k].v, tbl[k].i, tbl[k].oe, tbl[k].se, tbl[k].lk, tbl[k].e);
        end

        // async reset mid-cycle clears outputs without a clock edge
        go = 1; one_hot_in = 8'h01; clr_err = 0;
        #2 nreset = 0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk) nreset = 1;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            int r;
            go = ($urandom_range(0, 3) != 0);
            clr_err = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 9);
            if (r < 5) one_hot_in = 8'd1 << m_exp;
            else if (r < 7) one_hot_in = 8'd1 << $urandom_range(0, 7);
            else one_hot_in = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 nreset = 0;
                model_reset();
                #1 chk_all("rnd_rst", 0, 0, 0, 0, 0, 0);
                @(negedge clk) nreset = 1;
            end else begin
                model_step(go, one_hot_in, clr_err);
                @(negedge clk);
                chk_all("rnd", int'(m_v), m_idx, int'(m_oe), int'(m_se), int'(m_state == 2), m_err);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
